seg_scan_decoder: RTL and testbench
===================================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the segment encoder: watches a multiplexed seven-segment bus (segment lines plus one-hot digit strobes) and decodes each strobed pattern back to a 4-bit hex value.
- Stores one decoded value per digit position.
- Used in the display self-check / loopback path and for capturing external display boards.
- Accepts a pattern only after it has been stable for a programmable number of cycles, rejecting scan transitions and ghosting.

Parameters:
- NUM_DIGITS, 4, number of digit positions; legal range 1..8.
- STABLE_CYCLES, 4, consecutive identical samples required before a pattern is accepted; legal range 2..15.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- SegIn  input  7  segment lines, active-high; bit6=a, bit5=b … bit0=g (same encoding `SegsBus` carries).
- DigitSel  input  NUM_DIGITS  digit strobes, active-high, expected one-hot.
- ErrClr  input  1  one-cycle pulse; clears SelErr and all BadPat bits.
- DigitsOut  output  4*NUM_DIGITS  decoded values; digit i in bits [4i+3:4i].
- Blank  output  NUM_DIGITS  digit i last captured as all-segments-off.
- BadPat  output  NUM_DIGITS  sticky: digit i last captured a non-decodable pattern.
- Update  output  1  one-cycle pulse on each accepted capture.
- UpdIdx  output  3  index of the digit written by the current Update.
- SelErr  output  1  sticky: a stable multi-hot DigitSel was seen.

Behaviour:
- Clock and reset: all state on the rising edge of clk; reset is synchronous, active-high, priority over everything.
- Reset values:
  - DigitsOut = 0, Blank = all 1, BadPat = 0.
  - Update = 0, UpdIdx = 0, SelErr = 0.
  - Stability counter and sample registers = 0.
- Reset mid-run: any partially accumulated run is discarded; counting restarts from the first post-reset sample.
- Input sampling: {SegIn, DigitSel} registered every cycle. Any difference from the previous sample restarts the run count at 1; otherwise the count increments, saturating at STABLE_CYCLES.
- Acceptance: fires exactly once per stable run, on the cycle the count first reaches STABLE_CYCLES. Holding the value longer causes no re-fire; a new run is needed.
- Latency: inputs applied before edge E1 and held → storage, Update and UpdIdx change at edge E(STABLE_CYCLES+1). Update is high for exactly that one cycle.
- Strobe rules at acceptance:
  - DigitSel one-hot, bit i: capture into slot i, UpdIdx = i, Update = 1.
  - DigitSel all zero: no capture, no Update, no error.
  - DigitSel multi-hot: no capture, no Update, SelErr <= 1.
- Pattern decode (slot i):
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4, 1011011→5, 1011111→6, 1110000→7.
  - 1111111→8, 1110011→9, 1110111→A, 0011111→b, 1001110→C, 0111101→d, 1001111→E, 1000111→F.
  - Valid pattern: nibble = value, Blank[i] = 0, BadPat[i] = 0.
  - 0000000: nibble = 0, Blank[i] = 1, BadPat[i] = 0.
  - Any other pattern: nibble and Blank[i] unchanged, BadPat[i] = 1; Update still pulses.
- ErrClr:
  - Clears SelErr and all BadPat on the same edge.
  - If the same edge sets BadPat[j] or SelErr, the set wins for that bit only.
- Other slots are never modified by a capture.
- No internal state machine beyond sample register, run counter and storage. Two-flop synchronisation of SegIn/DigitSel is the instantiating level's responsibility.

Test Plan:
- Reset, then hold SegIn=1111001, DigitSel=0001 for 6 cycles → Update high exactly once at edge 5, UpdIdx=0, DigitsOut[3:0]=3, Blank=1110, BadPat=0.
- Scan 4 digits with patterns for 1, A, d, 7, each held 6 cycles with 1-cycle all-zero gaps → DigitsOut=16'h7DA1, four Update pulses, UpdIdx 0,1,2,3.
- Pattern for 8 toggling to 0 every 3 cycles on digit 2 (never reaches 4 stable) → no Update, DigitsOut unchanged.
- Digit 1 held at 1010101 → Update, BadPat=0010, prior nibble kept. Then ErrClr pulse → BadPat=0000. Then digit 1 held at 0000000 → Blank[1]=1, nibble 0.
- DigitSel=0110 held 6 cycles → SelErr=1, no Update. ErrClr on the same edge as a second multi-hot acceptance → SelErr stays 1.
- Assert rst at count 3 of a stable run, release, keep input → DigitsOut=0, Blank all 1; Update appears 5 edges after release.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
// Watches a multiplexed seven-segment bus and recovers one hex nibble per
// digit position. A {SegIn, DigitSel} sample must repeat for STABLE_CYCLES
// consecutive cycles before it is accepted, which filters out scan
// transitions and ghosting. Each stable run is accepted exactly once.
module seg_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [6:0]                SegIn,
    input  logic [NUM_DIGITS-1:0]     DigitSel,
    input  logic                      ErrClr,
    output logic [4*NUM_DIGITS-1:0]   DigitsOut,
    output logic [NUM_DIGITS-1:0]     Blank,
    output logic [NUM_DIGITS-1:0]     BadPat,
    output logic                      Update,
    output logic [2:0]                UpdIdx,
    output logic                      SelErr
);

    localparam int         SAMPLE_W = 7 + NUM_DIGITS;
    localparam logic [3:0] STABLE_C = 4'(STABLE_CYCLES);

    // Input sample and run-length tracking.
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  accept_q, accept_d;

    // Decoded storage and status.
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   badpat_q, badpat_d;
    logic                    update_q, update_d;
    logic [2:0]              upd_idx_q, upd_idx_d;
    logic                    selerr_q, selerr_d;

    // Fields of the sample being accepted.
    logic [6:0]            cap_seg;
    logic [NUM_DIGITS-1:0] cap_sel;
    logic [4:0]            dec;

    // Segment pattern (a..g on bits 6..0) to {valid, nibble}.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'b1111110: decode_seg = 5'h10;
            7'b0110000: decode_seg = 5'h11;
            7'b1101101: decode_seg = 5'h12;
            7'b1111001: decode_seg = 5'h13;
            7'b0110011: decode_seg = 5'h14;
            7'b1011011: decode_seg = 5'h15;
            7'b1011111: decode_seg = 5'h16;
            7'b1110000: decode_seg = 5'h17;
            7'b1111111: decode_seg = 5'h18;
            7'b1110011: decode_seg = 5'h19;
            7'b1110111: decode_seg = 5'h1A;
            7'b0011111: decode_seg = 5'h1B;
            7'b1001110: decode_seg = 5'h1C;
            7'b0111101: decode_seg = 5'h1D;
            7'b1001111: decode_seg = 5'h1E;
            7'b1000111: decode_seg = 5'h1F;
            default:    decode_seg = 5'h00;
        endcase
    endfunction

    // Run counter: restart on any change, saturate at STABLE_CYCLES, and flag
    // the single cycle on which the count first reaches the threshold.
    always_comb begin
        sample_d = {SegIn, DigitSel};
        if (sample_d != sample_q) begin
            cnt_d = 4'd1;
        end else if (cnt_q < STABLE_C) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = cnt_q;
        end
        accept_d = (cnt_d == STABLE_C) && (cnt_q != STABLE_C);
    end

    // Capture the accepted sample into its slot and update sticky errors.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        cap_seg   = sample_q[SAMPLE_W-1 -: 7];
        cap_sel   = sample_q[NUM_DIGITS-1:0];
        dec       = decode_seg(cap_seg);
        digits_d  = digits_q;
        blank_d   = blank_q;
        badpat_d  = ErrClr ? '0 : badpat_q;
        selerr_d  = selerr_q & ~ErrClr;
        update_d  = 1'b0;
        upd_idx_d = upd_idx_q;

        if (accept_q) begin
            if ($onehot(cap_sel)) begin
                update_d = 1'b1;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cap_sel[i]) begin
                        upd_idx_d = 3'(i);
                        if (dec[4]) begin
                            digits_d[4*i +: 4] = dec[3:0];
                            blank_d[i]         = 1'b0;
                            badpat_d[i]        = 1'b0;
                        end else if (cap_seg == 7'd0) begin
                            digits_d[4*i +: 4] = 4'h0;
                            blank_d[i]         = 1'b1;
                            badpat_d[i]        = 1'b0;
                        end else begin
                            // Undecodable: keep the old nibble, only flag it.
                            badpat_d[i]        = 1'b1;
                        end
                    end
                end
            end else if (cap_sel != '0) begin
                selerr_d = 1'b1;
            end
        end
    end

    // State registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            sample_q  <= '0;
            cnt_q     <= '0;
            accept_q  <= 1'b0;
            digits_q  <= '0;
            blank_q   <= '1;
            badpat_q  <= '0;
            update_q  <= 1'b0;
            upd_idx_q <= '0;
            selerr_q  <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            cnt_q     <= cnt_d;
            accept_q  <= accept_d;
            digits_q  <= digits_d;
            blank_q   <= blank_d;
            badpat_q  <= badpat_d;
            update_q  <= update_d;
            upd_idx_q <= upd_idx_d;
            selerr_q  <= selerr_d;
        end
    end

    assign DigitsOut = digits_q;
    assign Blank     = blank_q;
    assign BadPat    = badpat_q;
    assign Update    = update_q;
    assign UpdIdx    = upd_idx_q;
    assign SelErr    = selerr_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed steps from the test plan
// followed by randomized runs, all compared against a window-based model.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;
    localparam logic [6:0] PAT_TAB [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1110011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    logic              clk = 1'b0;
    logic              rst;
    logic [6:0]        SegIn;
    logic [ND-1:0]     DigitSel;
    logic              ErrClr;
    logic [4*ND-1:0]   DigitsOut;
    logic [ND-1:0]     Blank;
    logic [ND-1:0]     BadPat;
    logic              Update;
    logic [2:0]        UpdIdx;
    logic              SelErr;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .rst      (rst),
        .SegIn    (SegIn),
        .DigitSel (DigitSel),
        .ErrClr   (ErrClr),
        .DigitsOut(DigitsOut),
        .Blank    (Blank),
        .BadPat   (BadPat),
        .Update   (Update),
        .UpdIdx   (UpdIdx),
        .SelErr   (SelErr)
    );

    always #5 clk = ~clk;

    int errors  = 0;
    int checks  = 0;
    int obs_upd = 0;

    // Reference model: history of samples since reset plus expected outputs.
    logic [6+ND:0]   hist[$];
    logic [4*ND-1:0] m_digits;
    logic [ND-1:0]   m_blank;
    logic [ND-1:0]   m_bad;
    logic            m_upd;
    logic [2:0]      m_idx;
    logic            m_selerr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // A run is accepted on the edge after its STABLE_CYCLES-th identical
    // sample, provided the sample before that window differed (or did not
    // exist since reset).
    task automatic model_edge(input logic [6:0] s, input logic [ND-1:0] d,
                              input logic c, input logic r);
        int n;
        bit acc;
        logic [6:0]    vs;
        logic [ND-1:0] vd;
        int ones, pos, val;
        if (r) begin
            hist.delete();
            m_digits = '0; m_blank = '1; m_bad = '0;
            m_upd = 1'b0; m_idx = '0; m_selerr = 1'b0;
            return;
        end
        m_upd = 1'b0;
        if (c) begin
            m_bad = '0;
            m_selerr = 1'b0;
        end
        n = hist.size();
        acc = 0;
        if (n >= SC) begin
            acc = 1;
            for (int j = 1; j < SC; j++)
                if (hist[n-1-j] !== hist[n-1]) acc = 0;
            if (n > SC && hist[n-1-SC] === hist[n-1]) acc = 0;
        end
        if (acc) begin
            {vs, vd} = hist[n-1];
            ones = 0; pos = 0;
            for (int i = 0; i < ND; i++) if (vd[i]) begin ones++; pos = i; end
            if (ones == 1) begin
                m_upd = 1'b1;
                m_idx = 3'(pos);
                val = -1;
                for (int k = 0; k < 16; k++) if (PAT_TAB[k] == vs) val = k;
                if (val >= 0) begin
                    m_digits[4*pos +: 4] = 4'(val);
                    m_blank[pos] = 1'b0;
                    m_bad[pos] = 1'b0;
                end else if (vs == 7'd0) begin
                    m_digits[4*pos +: 4] = 4'h0;
                    m_blank[pos] = 1'b1;
                    m_bad[pos] = 1'b0;
                end else begin
                    m_bad[pos] = 1'b1;
                end
            end else if (ones > 1) begin
                m_selerr = 1'b1;
            end
        end
        hist.push_back({s, d});
        if (hist.size() > SC + 1) void'(hist.pop_front());
    endtask

    // One clock: drive at the falling edge, model on the rising edge, check 1ns later.
    task automatic cyc(input logic [6:0] s, input logic [ND-1:0] d,
                       input logic c = 1'b0, input logic r = 1'b0);
        SegIn = s; DigitSel = d; ErrClr = c; rst = r;
        @(posedge clk);
        model_edge(s, d, c, r);
        #1;
        if (Update === 1'b1) obs_upd++;
        chk("update",  32'(Update),    32'(m_upd));
        chk("upd_idx", 32'(UpdIdx),    32'(m_idx));
        chk("digits",  32'(DigitsOut), 32'(m_digits));
        chk("blank",   32'(Blank),     32'(m_blank));
        chk("badpat",  32'(BadPat),    32'(m_bad));
        chk("selerr",  32'(SelErr),    32'(m_selerr));
        @(negedge clk);
    endtask

    initial begin
        int base;
        int upd_edge;
        logic [6:0]    rs;
        logic [ND-1:0] rd;
        int len;

        SegIn = '0; DigitSel = '0; ErrClr = 1'b0; rst = 1'b1;
        @(negedge clk);

        // Reset state.
        cyc(7'd0, 4'd0, 1'b0, 1'b1);
        cyc(7'd0, 4'd0, 1'b0, 1'b1);
        chk("rst_digits", 32'(DigitsOut), 32'h0);
        chk("rst_blank",  32'(Blank),     32'hF);

        // Single digit "3" on slot 0, held 6 cycles.
        base = obs_upd;
        upd_edge = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc(7'b1111001, 4'b0001);
            if (Update === 1'b1) upd_edge = k;
        end
        chk("t1_updates", 32'(obs_upd - base), 32'd1);
        chk("t1_edge",    32'(upd_edge),       32'd5);
        chk("t1_nibble",  32'(DigitsOut[3:0]), 32'h3);
        chk("t1_blank",   32'(Blank),          32'hE);

        // Four-digit scan: 1, A, d, 7 with one-cycle blank gaps.
        base = obs_upd;
        repeat (6) cyc(7'b0110000, 4'b0001); cyc(7'd0, 4'd0);
        repeat (6) cyc(7'b1110111, 4'b0010); cyc(7'd0, 4'd0);
        repeat (6) cyc(7'b0111101, 4'b0100); cyc(7'd0, 4'd0);
        repeat (6) cyc(7'b1110000, 4'b1000); cyc(7'd0, 4'd0);
        chk("t2_updates", 32'(obs_upd - base), 32'd4);
        chk("t2_digits",  32'(DigitsOut),      32'h7DA1);

        // Ghosting on digit 2: never stable long enough.
        base = obs_upd;
        repeat (4) begin
            repeat (3) cyc(7'b1111111, 4'b0100);
            repeat (3) cyc(7'b0000000, 4'b0100);
        end
        chk("t3_updates", 32'(obs_upd - base), 32'd0);
        chk("t3_digits",  32'(DigitsOut),      32'h7DA1);

        // Bad pattern, clear, then blank on digit 1.
        base = obs_upd;
        repeat (6) cyc(7'b1010101, 4'b0010);
        chk("t4_updates", 32'(obs_upd - base), 32'd1);
        chk("t4_badpat",  32'(BadPat),         32'h2);
        chk("t4_kept",    32'(DigitsOut),      32'h7DA1);
        cyc(7'd0, 4'd0, 1'b1);
        chk("t4_clr",     32'(BadPat),         32'h0);
        repeat (6) cyc(7'b0000000, 4'b0010);
        chk("t4_blank",   32'(Blank),          32'h2);
        chk("t4_zero",    32'(DigitsOut),      32'h7D01);

        // Multi-hot strobes, then ErrClr colliding with a second multi-hot accept.
        base = obs_upd;
        repeat (6) cyc(7'b1111110, 4'b0110);
        chk("t5_selerr",  32'(SelErr),         32'd1);
        chk("t5_updates", 32'(obs_upd - base), 32'd0);
        cyc(7'd0, 4'd0, 1'b1);
        chk("t5_clr",     32'(SelErr),         32'd0);
        repeat (4) cyc(7'b1111110, 4'b0110);
        cyc(7'b1111110, 4'b0110, 1'b1);
        chk("t5_setwins", 32'(SelErr),         32'd1);

        // Reset in the middle of a stable run.
        cyc(7'd0, 4'd0);
        repeat (3) cyc(7'b1111110, 4'b0001);
        cyc(7'b1111110, 4'b0001, 1'b0, 1'b1);
        chk("t6_digits",  32'(DigitsOut), 32'h0);
        chk("t6_blank",   32'(Blank),     32'hF);
        upd_edge = 0;
        for (int k = 1; k <= 6; k++) begin
            cyc(7'b1111110, 4'b0001);
            if (Update === 1'b1 && upd_edge == 0) upd_edge = k;
        end
        chk("t6_latency", 32'(upd_edge), 32'd5);

        // Randomized runs.
        for (int t = 0; t < 250; t++) begin
            case ($urandom_range(0, 9))
                7:       rs = 7'd0;
                8, 9:    rs = 7'($urandom);
                default: rs = PAT_TAB[$urandom_range(0, 15)];
            endcase
            case ($urandom_range(0, 9))
                0:       rd = '0;
                1:       rd = ND'($urandom);
                default: rd = ND'(1) << $urandom_range(0, ND - 1);
            endcase
            len = $urandom_range(1, 7);
            for (int k = 0; k < len; k++)
                cyc(rs, rd, ($urandom_range(0, 11) == 0), ($urandom_range(0, 59) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
